// File: rtl/cnn_bias_relu.sv
// cnn_bias_relu: per-output-channel FP32 bias add followed by ReLU, downstream of the 3x3 conv.
// Define CNN_BIAS_RELU_EN to enable the ReLU clamp; otherwise the raw bias sum is passed through.

module fp_add_sub (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] result
);
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap, big_s, sticky, spec;
    logic [7:0]  ea, eb, big_e, sml_e, d;
    logic [23:0] ma, mb, big_m, sml_m;
    logic [26:0] sml_x, sh, sml_sh;
    logic [31:0] spec_val;

    logic        s1_vld, s1_sign, s1_sub, s1_spec;
    logic [7:0]  s1_exp;
    logic [26:0] s1_big, s1_small;
    logic [31:0] s1_spec_val;

    // Stage 1: unpack (subnormals flushed to zero), order by magnitude, align with sticky.
    always_comb begin
        sa    = a[31];
        sb    = b[31] ^ sub;
        ea    = a[30:23];
        eb    = b[30:23];
        ma    = (ea == '0) ? '0 : {1'b1, a[22:0]};
        mb    = (eb == '0) ? '0 : {1'b1, b[22:0]};
        a_nan = (ea == '1) && (a[22:0] != '0);
        b_nan = (eb == '1) && (b[22:0] != '0);
        a_inf = (ea == '1) && (a[22:0] == '0);
        b_inf = (eb == '1) && (b[22:0] == '0);
        swap  = {eb, b[22:0]} > {ea, a[22:0]};
        big_s = swap ? sb : sa;
        big_e = swap ? eb : ea;
        big_m = swap ? mb : ma;
        sml_e = swap ? ea : eb;
        sml_m = swap ? ma : mb;
        d     = big_e - sml_e;
        sml_x = {sml_m, 3'b000};
        if (d > 8'd26) begin
            sh     = '0;
            sticky = (sml_m != '0);
        end else begin
            sh     = sml_x >> d;
            sticky = (sml_x & ((27'd1 << d) - 27'd1)) != '0;
        end
        sml_sh = {sh[26:1], sh[0] | sticky};
        spec   = (ea == '1) || (eb == '1);
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            spec_val = 32'h7FC0_0000;
        else if (a_inf)
            spec_val = {sa, 8'hFF, 23'd0};
        else
            spec_val = {sb, 8'hFF, 23'd0};
    end

    always_ff @(posedge clk) begin
        if (reset) s1_vld <= 1'b0;
        else       s1_vld <= valid_in;
        s1_sign     <= big_s;
        s1_sub      <= sa ^ sb;
        s1_exp      <= big_e;
        s1_big      <= {big_m, 3'b000};
        s1_small    <= sml_sh;
        s1_spec     <= spec;
        s1_spec_val <= spec_val;
    end

    logic [27:0]       sum;
    logic [26:0]       norm;
    logic [4:0]        lz;
    logic signed [9:0] e_n;
    logic [24:0]       rnd;
    logic [22:0]       frac;
    logic              up;
    logic [31:0]       res;

    // Stage 2: add, normalise, round to nearest even, saturate to inf / flush to zero.
    always_comb begin
        sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small}) : ({1'b0, s1_big} + {1'b0, s1_small});
        lz  = '0;
        for (int unsigned i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e_n  = $signed({2'b00, s1_exp}) + 10'sd1;
        end else begin
            norm = sum[26:0] << lz;
            e_n  = $signed({2'b00, s1_exp}) - $signed({5'b00000, lz});
        end
        up   = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd  = {1'b0, norm[26:3]} + 25'(up);
        if (rnd[24]) e_n = e_n + 10'sd1;
        frac = rnd[24] ? rnd[23:1] : rnd[22:0];
        if (s1_spec)              res = s1_spec_val;
        else if (sum == '0)       res = {s1_sign & ~s1_sub, 31'd0};
        else if (e_n >= 10'sd255) res = {s1_sign, 8'hFF, 23'd0};
        else if (e_n <= 10'sd0)   res = {s1_sign, 31'd0};
        else                      res = {s1_sign, e_n[7:0], frac};
    end

    always_ff @(posedge clk) begin
        if (reset) valid_out <= 1'b0;
        else       valid_out <= s1_vld;
        result <= res;
    end
endmodule

module cnn_bias_relu #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 612,
    parameter int IMAGE_HEIGHT    = 612,
    parameter int CHANNEL_NUM_OUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stride2,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  bias_ready,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done,
    output logic                  err_drop
);
    localparam int CW = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam int PW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT + 1);
    localparam logic [CW-1:0] CH_LAST        = CW'(CHANNEL_NUM_OUT - 1);
    localparam logic [PW-1:0] PIX_LAST_FULL  = PW'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
    localparam logic [PW-1:0] PIX_LAST_HALF  = PW'((IMAGE_WIDTH / 2) * (IMAGE_HEIGHT / 2) - 1);

    typedef enum logic {LOAD, RUN} state_t;
    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] bias_tab [CHANNEL_NUM_OUT];
    logic [CW-1:0]         wr_ptr, ch_cnt, oc_cnt;
    logic [PW-1:0]         pix_cnt, pix_last;
    logic                  stride_q, load_we, issue, add_vld;
    logic [DATA_WIDTH-1:0] sum, relu_val;

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == LOAD && valid_bias_in && wr_ptr == CH_LAST) state_nx = RUN;
    end

    always_comb begin
        load_we    = (state == LOAD) && valid_bias_in;
        issue      = (state == RUN) && valid_in;
        bias_ready = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (load_we) bias_tab[wr_ptr] <= bias_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            ch_cnt   <= '0;
            stride_q <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            if (load_we) begin
                wr_ptr <= (wr_ptr == CH_LAST) ? '0 : wr_ptr + 1'b1;
                if (wr_ptr == CH_LAST) stride_q <= stride2;
            end
            if (issue) ch_cnt <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
            if (valid_in && state == LOAD) err_drop <= 1'b1;
        end
    end

    fp_add_sub u_add (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (issue),
        .sub       (1'b0),
        .a         (pxl_in),
        .b         (bias_tab[ch_cnt]),
        .valid_out (add_vld),
        .result    (sum)
    );

    always_comb begin
`ifdef CNN_BIAS_RELU_EN
        relu_val = sum[DATA_WIDTH-1] ? '0 : sum;
`else
        relu_val = sum;
`endif
        pix_last = stride_q ? PIX_LAST_HALF : PIX_LAST_FULL;
    end

    // Output channel/pixel counters advance with the word entering the output register,
    // so frame_done lines up with the valid_out of the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            pxl_out    <= '0;
            oc_cnt     <= '0;
            pix_cnt    <= '0;
        end else begin
            valid_out  <= add_vld;
            frame_done <= 1'b0;
            if (add_vld) begin
                pxl_out <= relu_val;
                if (oc_cnt == CH_LAST) begin
                    oc_cnt <= '0;
                    if (pix_cnt == pix_last) begin
                        pix_cnt    <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end else begin
                    oc_cnt <= oc_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cnn_bias_relu.sv
// Scoreboard bench for cnn_bias_relu: a default-size instance plus a 4x4, 2-channel instance for frame tests.
module tb_cnn_bias_relu;
    localparam int L_ADD  = 2;
    localparam int C_BIG  = 64;
    localparam int C_SM   = 2;
    localparam int S_WORDS = (4 / 2) * (4 / 2) * C_SM;
    localparam logic [31:0] ONE = 32'h3F80_0000;

    typedef struct {
        logic [31:0] data;
        logic        fd;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        b_stride2, b_vbias, b_vin, b_ready, b_vout, b_fd, b_err;
    logic [31:0] b_bias, b_pxl, b_pout;
    logic        s_stride2, s_vbias, s_vin, s_ready, s_vout, s_fd, s_err;
    logic [31:0] s_bias, s_pxl, s_pout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ev_t         b_obs[$], b_exp[$], s_obs[$], s_exp[$];
    logic [31:0] b_tab [C_BIG];
    logic [31:0] s_tab [C_SM];
    int          b_ch, s_ch, s_word;

    cnn_bias_relu dut (
        .clk(clk), .reset(reset), .stride2(b_stride2), .valid_bias_in(b_vbias), .bias_in(b_bias),
        .valid_in(b_vin), .pxl_in(b_pxl), .bias_ready(b_ready), .pxl_out(b_pout),
        .valid_out(b_vout), .frame_done(b_fd), .err_drop(b_err)
    );

    cnn_bias_relu #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_OUT(C_SM)) dut_small (
        .clk(clk), .reset(reset), .stride2(s_stride2), .valid_bias_in(s_vbias), .bias_in(s_bias),
        .valid_in(s_vin), .pxl_in(s_pxl), .bias_ready(s_ready), .pxl_out(s_pout),
        .valid_out(s_vout), .frame_done(s_fd), .err_drop(s_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b_vout || b_fd) b_obs.push_back(ev_t'{b_pout, b_fd, cyc});
        if (s_vout || s_fd) s_obs.push_back(ev_t'{s_pout, s_fd, cyc});
    end

    function automatic real fp2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return f[31] ? -0.0 : 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2fp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] f);
`ifdef CNN_BIAS_RELU_EN
        return f[31] ? 32'h0 : f;
`else
        return f;
`endif
    endfunction

    function automatic logic [31:0] rnd_px();
        return r2fp((real'($urandom_range(0, 160)) - 80.0) / 4.0);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        b_vin = 1'b0; b_vbias = 1'b0; s_vin = 1'b0; s_vbias = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        b_obs.delete(); b_exp.delete(); s_obs.delete(); s_exp.delete();
        b_ch = 0; s_ch = 0; s_word = 0;
    endtask

    task automatic b_issue(input logic [31:0] p);
        b_vin = 1'b1;
        b_pxl = p;
        b_exp.push_back(ev_t'{relu(r2fp(fp2r(p) + fp2r(b_tab[b_ch]))), 1'b0, cyc + L_ADD + 1});
        b_ch = (b_ch + 1) % C_BIG;
        @(negedge clk);
        b_vin = 1'b0;
    endtask

    task automatic s_issue(input logic [31:0] p);
        s_vin = 1'b1;
        s_pxl = p;
        s_exp.push_back(ev_t'{relu(r2fp(fp2r(p) + fp2r(s_tab[s_ch]))),
                              (s_word % S_WORDS) == S_WORDS - 1, cyc + L_ADD + 1});
        s_ch = (s_ch + 1) % C_SM;
        s_word++;
        @(negedge clk);
        s_vin = 1'b0;
    endtask

    task automatic b_load_ramp();
        for (int i = 0; i < C_BIG; i++) begin
            b_tab[i] = r2fp(real'(i) - 20.0);
            b_vbias  = 1'b1;
            b_bias   = b_tab[i];
            @(negedge clk);
        end
        b_vbias = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_bias_ready: got %b want 0", b_ready); end
        n_checks++; if (b_vout !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b want 0", b_vout); end
        n_checks++; if (b_fd !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", b_fd); end
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL reset_err_drop: got %b want 0", b_err); end
        n_checks++; if (b_pout !== 32'h0) begin n_fail++; $display("FAIL reset_pxl_out: got %h want 0", b_pout); end
    endtask

    task automatic test_load();
        for (int i = 0; i < C_BIG; i++) begin
            b_tab[i] = ONE;
            b_vbias  = 1'b1;
            b_bias   = ONE;
            if (i == C_BIG - 1) begin
                n_checks++;
                if (b_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_early: got %b want 0", b_ready); end
            end
            @(negedge clk);
        end
        b_vbias = 1'b0;
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", b_ready); end
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL load_err_drop: got %b want 0", b_err); end
    endtask

    task automatic test_latency();
        ev_t o;
        int  t0;
        t0 = cyc;
        b_vin = 1'b1; b_pxl = 32'h4000_0000;
        @(negedge clk);
        b_vin = 1'b0; b_ch = 1;
        repeat (L_ADD + 3) @(negedge clk);
        n_checks++;
        if (b_obs.size() != 1) begin
            n_fail++; $display("FAIL latency_count: got %0d outputs want 1", b_obs.size());
            b_obs.delete();
        end else begin
            o = b_obs.pop_front();
            n_checks++;
            if (o.data !== 32'h4040_0000 || o.cyc != t0 + L_ADD + 1 || o.fd !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_data: got %h at cyc %0d want 40400000 at cyc %0d", o.data, o.cyc, t0 + L_ADD + 1);
            end
        end
    endtask

    task automatic test_relu();
        ev_t e, o;
        logic [31:0] vals [5] = '{32'hC040_0000, 32'hBF80_0000, 32'hC0A0_0000, 32'h3F00_0000, 32'h8000_0000};
        foreach (vals[i]) b_issue(vals[i]);
        repeat (L_ADD + 4) @(negedge clk);
        while (b_exp.size() > 0) begin
            e = b_exp.pop_front();
            n_checks++;
            if (b_obs.size() == 0) begin
                n_fail++; $display("FAIL relu_missing: got none want %h at cyc %0d", e.data, e.cyc);
            end else begin
                o = b_obs.pop_front();
                if (o.data !== e.data || o.fd !== e.fd || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL relu_out: got %h fd=%b cyc=%0d want %h fd=%b cyc=%0d", o.data, o.fd, o.cyc, e.data, e.fd, e.cyc);
                end
            end
        end
        n_checks++; if (b_obs.size() != 0) begin n_fail++; $display("FAIL relu_extra: got %0d extra outputs want 0", b_obs.size()); b_obs.delete(); end
    endtask

    task automatic test_run_ignores_bias();
        ev_t e, o;
        b_vbias = 1'b1; b_bias = 32'h40A0_0000;
        @(negedge clk);
        b_vbias = 1'b0;
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b want 1", b_ready); end
        for (int i = 0; i < C_BIG + 4; i++) b_issue(rnd_px());
        repeat (L_ADD + 4) @(negedge clk);
        while (b_exp.size() > 0) begin
            e = b_exp.pop_front();
            n_checks++;
            if (b_obs.size() == 0) begin
                n_fail++; $display("FAIL run_bias_missing: got none want %h at cyc %0d", e.data, e.cyc);
            end else begin
                o = b_obs.pop_front();
                if (o.data !== e.data || o.fd !== e.fd || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL run_bias_out: got %h fd=%b cyc=%0d want %h fd=%b cyc=%0d", o.data, o.fd, o.cyc, e.data, e.fd, e.cyc);
                end
            end
        end
        n_checks++; if (b_obs.size() != 0) begin n_fail++; $display("FAIL run_bias_extra: got %0d extra want 0", b_obs.size()); b_obs.delete(); end
    endtask

    task automatic test_reset_inflight();
        b_vin = 1'b1; b_pxl = ONE;
        @(negedge clk);
        b_pxl = 32'h4000_0000;
        @(negedge clk);
        b_pxl = 32'h4040_0000;
        reset = 1'b1;
        @(negedge clk);
        b_vin = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        b_exp.delete(); b_ch = 0;
        repeat (L_ADD + 6) @(negedge clk);
        n_checks++; if (b_obs.size() != 0) begin n_fail++; $display("FAIL inflight_out: got %0d outputs want 0", b_obs.size()); b_obs.delete(); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL inflight_ready: got %b want 0", b_ready); end
    endtask

    task automatic test_load_drop();
        b_vin = 1'b1; b_pxl = ONE;
        repeat (2) @(negedge clk);
        b_vin = 1'b0;
        repeat (L_ADD + 4) @(negedge clk);
        n_checks++; if (b_obs.size() != 0) begin n_fail++; $display("FAIL drop_out: got %0d outputs want 0", b_obs.size()); b_obs.delete(); end
        n_checks++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b want 1", b_err); end
        b_load_ramp();
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL drop_reload_ready: got %b want 1", b_ready); end
        n_checks++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL drop_err_sticky: got %b want 1", b_err); end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        for (int i = 0; i < 70; i++) b_issue(rnd_px());
        for (int i = 0; i < 12; i++) begin
            b_issue(rnd_px());
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (L_ADD + 4) @(negedge clk);
        while (b_exp.size() > 0) begin
            e = b_exp.pop_front();
            n_checks++;
            if (b_obs.size() == 0) begin
                n_fail++; $display("FAIL b2b_missing: got none want %h at cyc %0d", e.data, e.cyc);
            end else begin
                o = b_obs.pop_front();
                if (o.data !== e.data || o.fd !== e.fd || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL b2b_out: got %h fd=%b cyc=%0d want %h fd=%b cyc=%0d", o.data, o.fd, o.cyc, e.data, e.fd, e.cyc);
                end
            end
        end
        n_checks++; if (b_obs.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra want 0", b_obs.size()); b_obs.delete(); end
    endtask

    task automatic test_err_clear();
        do_reset();
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", b_err); end
    endtask

    task automatic test_frame();
        ev_t e, o;
        s_tab[0] = r2fp(0.5);
        s_tab[1] = r2fp(-1.5);
        s_stride2 = 1'b1;
        for (int i = 0; i < C_SM; i++) begin
            s_vbias = 1'b1; s_bias = s_tab[i];
            @(negedge clk);
        end
        s_vbias = 1'b0;
        s_stride2 = 1'b0;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL frame_ready: got %b want 1", s_ready); end
        for (int i = 0; i < S_WORDS; i++) s_issue(rnd_px());
        repeat (3) @(negedge clk);
        for (int i = 0; i < S_WORDS; i++) begin
            s_issue(rnd_px());
            @(negedge clk);
        end
        for (int i = 0; i < S_WORDS; i++) s_issue(rnd_px());
        repeat (L_ADD + 4) @(negedge clk);
        while (s_exp.size() > 0) begin
            e = s_exp.pop_front();
            n_checks++;
            if (s_obs.size() == 0) begin
                n_fail++; $display("FAIL frame_missing: got none want %h fd=%b at cyc %0d", e.data, e.fd, e.cyc);
            end else begin
                o = s_obs.pop_front();
                if (o.data !== e.data || o.fd !== e.fd || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL frame_out: got %h fd=%b cyc=%0d want %h fd=%b cyc=%0d", o.data, o.fd, o.cyc, e.data, e.fd, e.cyc);
                end
            end
        end
        n_checks++; if (s_obs.size() != 0) begin n_fail++; $display("FAIL frame_extra: got %0d extra want 0", s_obs.size()); s_obs.delete(); end
    endtask

    initial begin
        reset = 1'b1;
        b_stride2 = 1'b0; b_vbias = 1'b0; b_bias = '0; b_vin = 1'b0; b_pxl = '0;
        s_stride2 = 1'b0; s_vbias = 1'b0; s_bias = '0; s_vin = 1'b0; s_pxl = '0;
        test_reset();
        test_load();
        test_latency();
        test_relu();
        test_run_ignores_bias();
        test_reset_inflight();
        test_load_drop();
        test_back_to_back();
        test_err_clear();
        test_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
